// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game sequencer: loads a random delay, waits for the counter, times the Stop response.
// Optional BEST_TIME_EN keeps the fastest non-timeout reaction since reset on best_time.
module reaction_timer_ctrl #(
    parameter int N         = 15,
    parameter int M         = 14,
    parameter int MIN_DELAY = 256
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stop,
    input  logic         delay_done,
    output logic         cnt_en,
    output logic [N-1:0] delay_value,
    output logic         led,
    output logic [M-1:0] react_time,
    output logic         valid,
    output logic         too_early,
    output logic         timeout,
    output logic [M-1:0] best_time
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT, S_REACT, S_RESULT, S_FAULT
    } state_t;

    localparam logic [N-1:0] FLOOR   = N'(MIN_DELAY);
    localparam logic [M-1:0] CNT_MAX = '1;

    state_t         r_state;
    state_t         w_next;
    logic [15:0]    r_lfsr;
    logic [15:0]    w_lfsr_next;
    logic [M-1:0]   r_cnt;
    logic [N-1:0]   r_delay;
    logic [M-1:0]   r_react;
    logic           r_valid;
    logic           r_too_early;
    logic           r_timeout;
    logic           w_stop_hit;
    logic           w_saturate;

    function automatic logic [N-1:0] floor_delay(input logic [N-1:0] raw);
        return (raw < FLOOR) ? FLOOR : raw;
    endfunction

    assign w_lfsr_next = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400) : {1'b0, r_lfsr[15:1]};
    assign w_stop_hit  = (r_state == S_REACT) && Stop;
    assign w_saturate  = (r_state == S_REACT) && !Stop && (r_cnt == CNT_MAX);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_RESULT, S_FAULT: if (Start) w_next = S_ARM;
            S_ARM:                     w_next = S_WAIT;
            // Stop beats delay_done when both land in the same cycle
            S_WAIT: begin
                if (Stop)            w_next = S_FAULT;
                else if (delay_done) w_next = S_REACT;
            end
            S_REACT: if (Stop || (r_cnt == CNT_MAX)) w_next = S_RESULT;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_lfsr      <= 16'hACE1;
            r_cnt       <= '0;
            r_delay     <= '0;
            r_react     <= '0;
            r_valid     <= 1'b0;
            r_too_early <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_next;
            r_cnt  <= (r_state == S_REACT) ? r_cnt + M'(1) : '0;
            // New delay is in place for the whole ARM cycle so the counter loads it
            if (w_next == S_ARM) begin
                r_delay     <= floor_delay(r_lfsr[N-1:0]);
                r_valid     <= 1'b0;
                r_too_early <= 1'b0;
                r_timeout   <= 1'b0;
            end
            if ((r_state == S_WAIT) && Stop) r_too_early <= 1'b1;
            if (w_stop_hit) begin
                r_react <= r_cnt;
                r_valid <= 1'b1;
            end else if (w_saturate) begin
                r_react   <= CNT_MAX;
                r_valid   <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef BEST_TIME_EN
    logic [M-1:0] r_best;
    logic         r_have_best;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_best      <= '1;
            r_have_best <= 1'b0;
        end else if (w_stop_hit) begin
            r_have_best <= 1'b1;
            if (r_cnt < r_best) r_best <= r_cnt;
        end
    end

    assign best_time = r_have_best ? r_best : '0;
`else
    assign best_time = '0;
`endif

    assign cnt_en      = (r_state == S_WAIT);
    assign led         = (r_state == S_REACT);
    assign delay_value = r_delay;
    assign react_time  = r_react;
    assign valid       = r_valid;
    assign too_early   = r_too_early;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: vector table, directed corner rounds, random rounds vs a reference model.
// Build with BEST_TIME_EN defined to exercise the best-time tracker.
module tb_reaction_timer_ctrl;

    localparam int N = 15;
    localparam int M = 14;
    localparam int MIN_DELAY = 256;
    localparam int MS = 4;
    localparam int LFSR_PERIOD = 65535;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic         start = 1'b0, stop = 1'b0, done_stub = 1'b0, use_cnt = 1'b0;
    logic         w_done;
    logic         cnt_en, led, valid, too_early, timeout;
    logic [N-1:0] delay_value;
    logic [M-1:0] react_time, best_time;

    logic          s_start = 1'b0, s_stop = 1'b0, s_done = 1'b0;
    logic          s_cnt_en, s_led, s_valid, s_te, s_to;
    logic [N-1:0]  s_dv;
    logic [MS-1:0] s_rt, s_best;

    logic [N-1:0] uc_cnt, uc_tgt;
    logic         uc_done;

    assign w_done = use_cnt ? uc_done : done_stub;

    reaction_timer_ctrl #(.N(N), .M(M), .MIN_DELAY(MIN_DELAY)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(start), .Stop(stop), .delay_done(w_done),
        .cnt_en(cnt_en), .delay_value(delay_value), .led(led), .react_time(react_time),
        .valid(valid), .too_early(too_early), .timeout(timeout), .best_time(best_time)
    );

    reaction_timer_ctrl #(.N(N), .M(MS), .MIN_DELAY(MIN_DELAY)) u_small (
        .Clk(Clk), .Reset(Reset), .Start(s_start), .Stop(s_stop), .delay_done(s_done),
        .cnt_en(s_cnt_en), .delay_value(s_dv), .led(s_led), .react_time(s_rt),
        .valid(s_valid), .too_early(s_te), .timeout(s_to), .best_time(s_best)
    );

    // Up counter: En low loads random_num and clears; done once the count reaches it
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            uc_cnt <= '0; uc_tgt <= '0; uc_done <= 1'b0;
        end else if (!cnt_en) begin
            uc_cnt <= '0; uc_tgt <= delay_value; uc_done <= 1'b0;
        end else begin
            uc_cnt  <= uc_cnt + N'(1);
            uc_done <= ({1'b0, uc_cnt} + (N+1)'(1)) >= {1'b0, uc_tgt};
        end
    end

    // Clock edges since reset release; the LFSR value is looked up from a precomputed sequence
    int unsigned m_cyc;
    always @(posedge Clk or posedge Reset) begin
        if (Reset) m_cyc <= 0;
        else       m_cyc <= m_cyc + 1;
    end

    logic [15:0] lfsr_seq [0:LFSR_PERIOD-1];

    int n_cmp = 0;
    int n_err = 0;
    int exp_rt = 0;
    int exp_best = -1;

    typedef struct {
        bit st; bit sp; bit dn;
        bit en; bit ld; bit vl; bit te; bit to;
        int rt;
    } vec_t;
    vec_t tbl [26];

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ({1'b0, l[15:1]} ^ 16'hB400) : {1'b0, l[15:1]};
    endfunction

    function automatic int pred_delay();
        logic [15:0] l;
        int v;
        l = lfsr_seq[m_cyc % LFSR_PERIOD];
        v = int'(l[N-1:0]);
        return (v < MIN_DELAY) ? MIN_DELAY : v;
    endfunction

    function automatic int best_exp();
`ifdef BEST_TIME_EN
        return (exp_best < 0) ? 0 : exp_best;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // One round on the main DUT from IDLE/RESULT/FAULT; Stop in WAIT cycle wcyc if early,
    // otherwise done in WAIT cycle wcyc and Stop in REACT cycle k
    task automatic round(input int wcyc, input int k, input bit early);
        int dv;
        dv = pred_delay();
        start = 1'b1; tick(); start = 1'b0;
        chk("arm_delay", 32'(delay_value), 32'(dv));
        chk("arm_cnt_en", 32'(cnt_en), 0);
        chk("arm_valid", 32'(valid), 0);
        chk("arm_too_early", 32'(too_early), 0);
        tick();
        chk("wait_cnt_en", 32'(cnt_en), 1);
        repeat (wcyc - 1) tick();
        if (early) begin
            stop = 1'b1; tick(); stop = 1'b0;
            chk("fault_too_early", 32'(too_early), 1);
            chk("fault_valid", 32'(valid), 0);
            chk("fault_cnt_en", 32'(cnt_en), 0);
            chk("fault_led", 32'(led), 0);
            chk("fault_react", 32'(react_time), 32'(exp_rt));
        end else begin
            done_stub = 1'b1; tick(); done_stub = 1'b0;
            chk("react_led", 32'(led), 1);
            chk("react_cnt_en", 32'(cnt_en), 0);
            repeat (k - 1) tick();
            stop = 1'b1; tick(); stop = 1'b0;
            exp_rt = k - 1;
            if (exp_best < 0 || exp_rt < exp_best) exp_best = exp_rt;
            chk("result_react", 32'(react_time), 32'(exp_rt));
            chk("result_valid", 32'(valid), 1);
            chk("result_timeout", 32'(timeout), 0);
            chk("result_led", 32'(led), 0);
            chk("result_cnt_en", 32'(cnt_en), 0);
        end
        chk("best_time", 32'(best_time), 32'(best_exp()));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dv;
        lfsr_seq[0] = 16'hACE1;
        for (int i = 1; i < LFSR_PERIOD; i++) lfsr_seq[i] = lfsr_step(lfsr_seq[i-1]);

        tbl[0]  = '{0,0,0, 0,0,0,0,0, 0};
        tbl[1]  = '{0,1,1, 0,0,0,0,0, 0};
        tbl[2]  = '{1,0,0, 0,0,0,0,0, 0};
        tbl[3]  = '{0,0,0, 1,0,0,0,0, 0};
        tbl[4]  = '{0,1,0, 0,0,0,1,0, 0};
        tbl[5]  = '{0,1,0, 0,0,0,1,0, 0};
        tbl[6]  = '{1,0,0, 0,0,0,0,0, 0};
        tbl[7]  = '{0,0,0, 1,0,0,0,0, 0};
        tbl[8]  = '{0,1,1, 0,0,0,1,0, 0};
        tbl[9]  = '{1,0,0, 0,0,0,0,0, 0};
        tbl[10] = '{0,0,0, 1,0,0,0,0, 0};
        tbl[11] = '{0,0,1, 0,1,0,0,0, 0};
        tbl[12] = '{0,1,0, 0,0,1,0,0, 0};
        tbl[13] = '{1,0,0, 0,0,0,0,0, 0};
        tbl[14] = '{0,0,0, 1,0,0,0,0, 0};
        tbl[15] = '{0,0,1, 0,1,0,0,0, 0};
        tbl[16] = '{0,0,0, 0,1,0,0,0, 0};
        tbl[17] = '{0,0,0, 0,1,0,0,0, 0};
        tbl[18] = '{0,1,0, 0,0,1,0,0, 2};
        tbl[19] = '{0,1,0, 0,0,1,0,0, 2};
        tbl[20] = '{1,0,0, 0,0,0,0,0, 2};
        tbl[21] = '{1,0,0, 1,0,0,0,0, 2};
        tbl[22] = '{1,0,0, 1,0,0,0,0, 2};
        tbl[23] = '{1,0,1, 0,1,0,0,0, 2};
        tbl[24] = '{1,0,0, 0,1,0,0,0, 2};
        tbl[25] = '{0,1,0, 0,0,1,0,0, 1};

        // Reset state
        @(negedge Clk); @(negedge Clk);
        chk("rst_cnt_en", 32'(cnt_en), 0);
        chk("rst_led", 32'(led), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_too_early", 32'(too_early), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_react", 32'(react_time), 0);
        chk("rst_delay", 32'(delay_value), 0);
        chk("rst_best", 32'(best_time), 0);
        Reset = 1'b0;

        // Vector table: one cycle per record, outputs checked after the edge
        for (int i = 0; i < 26; i++) begin
            start = tbl[i].st; stop = tbl[i].sp; done_stub = tbl[i].dn;
            tick();
            chk($sformatf("vec%0d_cnt_en", i), 32'(cnt_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].ld));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].vl));
            chk($sformatf("vec%0d_too_early", i), 32'(too_early), 32'(tbl[i].te));
            chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(tbl[i].to));
            chk($sformatf("vec%0d_react", i), 32'(react_time), 32'(tbl[i].rt));
        end
        start = 1'b0; stop = 1'b0; done_stub = 1'b0;

        // Reset asserted mid-REACT takes effect before the next clock edge
        start = 1'b1; tick(); start = 1'b0;
        tick();
        done_stub = 1'b1; tick(); done_stub = 1'b0;
        tick();
        chk("pre_rst_led", 32'(led), 1);
        #2 Reset = 1'b1;
        #1;
        chk("async_led", 32'(led), 0);
        chk("async_cnt_en", 32'(cnt_en), 0);
        chk("async_react", 32'(react_time), 0);
        chk("async_valid", 32'(valid), 0);
        chk("async_delay", 32'(delay_value), 0);
        chk("async_best", 32'(best_time), 0);
        @(negedge Clk);
        Reset = 1'b0;
        exp_rt = 0; exp_best = -1;
        done_stub = 1'b1; tick(); done_stub = 1'b0;
        chk("idle_after_rst_cnt_en", 32'(cnt_en), 0);
        chk("idle_after_rst_led", 32'(led), 0);

        // Directed rounds: 37, 20, 50, then an early press
        round(5, 38, 1'b0);
        round(3, 21, 1'b0);
        round(2, 51, 1'b0);
        round(4, 1, 1'b1);
`ifdef BEST_TIME_EN
        chk("best_after_fault", 32'(best_time), 20);
`else
        chk("best_after_fault", 32'(best_time), 0);
`endif

        // Random rounds against the reference model
        for (int r = 0; r < 40; r++)
            round(int'($urandom_range(1, 8)), int'($urandom_range(1, 300)), $urandom_range(0, 4) == 0);

        // Many ARMs with the up counter attached: floor and LFSR sequence
        use_cnt = 1'b1;
        for (int r = 0; r < 1000; r++) begin
            dv = pred_delay();
            start = 1'b1; tick(); start = 1'b0;
            chk("arms_delay", 32'(delay_value), 32'(dv));
            chk("arms_floor", 32'(delay_value >= N'(MIN_DELAY)), 1);
            tick();
            stop = 1'b1; tick(); stop = 1'b0;
        end

        // One complete round timed by the up counter
        dv = pred_delay();
        start = 1'b1; tick(); start = 1'b0;
        chk("full_delay", 32'(delay_value), 32'(dv));
        tick();
        n = 0;
        while (!led && n < 40000) begin
            tick();
            n++;
        end
        chk("full_led_rose", 32'(led), 1);
        chk("full_wait_len", 32'((n >= dv) && (n <= dv + 2)), 1);
        stop = 1'b1; tick(); stop = 1'b0;
        exp_rt = 0; exp_best = 0;
        chk("full_react", 32'(react_time), 0);
        chk("full_valid", 32'(valid), 1);
        chk("full_best", 32'(best_time), 32'(best_exp()));
        use_cnt = 1'b0;

        // Saturation on the M=4 instance
        s_start = 1'b1; tick(); s_start = 1'b0;
        chk("sat_dv_floor", 32'(s_dv >= N'(MIN_DELAY)), 1);
        tick();
        chk("sat_wait_cnt_en", 32'(s_cnt_en), 1);
        s_done = 1'b1; tick(); s_done = 1'b0;
        chk("sat_led_first", 32'(s_led), 1);
        repeat (15) tick();
        chk("sat_led_16th", 32'(s_led), 1);
        chk("sat_timeout_early", 32'(s_to), 0);
        tick();
        chk("sat_react", 32'(s_rt), 15);
        chk("sat_timeout", 32'(s_to), 1);
        chk("sat_valid", 32'(s_valid), 1);
        chk("sat_led", 32'(s_led), 0);
        chk("sat_too_early", 32'(s_te), 0);
        chk("sat_best", 32'(s_best), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
